// File: rtl/branch_resolve_pkg.sv
// Shared types and constants for the branch/jump resolution stage:
// FSM state encoding, branch funct3 encodings, comparator-flag indices.
package branch_resolve_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVAL     = 2'd1,
    REDIRECT = 2'd2,
    FLUSH    = 2'd3
  } state_e;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_LT   = 1;
  localparam int FLAG_LTU  = 2;
  localparam int FLAG_N    = 3;

  // Wide enough for the largest legal FLUSH_CYCLES (15).
  localparam int FLUSH_CNT_W = 4;

  // funct3[2:1] picks the comparison, funct3[0] inverts it.
  function automatic logic [1:0] flag_sel(input logic [2:0] funct3);
    case (funct3[2:1])
      2'b10:   return 2'(FLAG_LT);
      2'b11:   return 2'(FLAG_LTU);
      default: return 2'(FLAG_ZERO);
    endcase
  endfunction

  function automatic logic funct3_legal(input logic [2:0] funct3);
    return funct3[2:1] != 2'b01;
  endfunction

endpackage

// File: rtl/branch_resolve_bitmux.sv
// Generic N-input single-bit multiplexer; out-of-range selects yield 0.
module bitmux #(
  parameter  int N     = 3,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     in_bits,
  input  logic [SEL_W-1:0] sel,
  output logic             out_bit
);

  // NOTE: assigning a default first in always_comb guarantees no latch is inferred.
  always_comb begin
    out_bit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) out_bit = in_bits[i];
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch/jump resolution stage: captures one control-transfer instruction,
// decides taken/not-taken, issues a PC redirect, then holds flush for a fixed width.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_branch,
  input  logic            in_jump,
  input  logic [2:0]      in_funct3,
  input  logic            in_zero,
  input  logic            in_lt,
  input  logic            in_ltu,
  input  logic [XLEN-1:0] in_target,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            illegal,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] resolved_cnt
);

  localparam logic [CNT_W-1:0]       CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  state_e                 state_q, state_d;
  logic                   branch_q, branch_d;
  logic                   jump_q, jump_d;
  logic [2:0]             funct3_q, funct3_d;
  logic [FLAG_N-1:0]      flags_q, flags_d;
  logic [XLEN-1:0]        target_q, target_d;
  logic [FLUSH_CNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0]       taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0]       resolved_cnt_q, resolved_cnt_d;

  logic [1:0] sel;
  logic       flag_bit;
  logic       legal;
  logic       taken;
  logic       counted;

  assign sel     = flag_sel(funct3_q);
  assign legal   = funct3_legal(funct3_q);
  assign taken   = jump_q | (branch_q & legal & (flag_bit ^ funct3_q[0]));
  assign counted = branch_q | jump_q;

  bitmux #(.N(FLAG_N)) u_flag_mux (
    .in_bits (flags_q),
    .sel     (sel),
    .out_bit (flag_bit)
  );

  always_comb begin
    state_d        = state_q;
    branch_d       = branch_q;
    jump_d         = jump_q;
    funct3_d       = funct3_q;
    flags_d        = flags_q;
    target_d       = target_q;
    fcnt_d         = fcnt_q;
    taken_cnt_d    = taken_cnt_q;
    resolved_cnt_d = resolved_cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          branch_d = in_branch;
          jump_d   = in_jump;
          funct3_d = in_funct3;
          flags_d  = {in_ltu, in_lt, in_zero};
          target_d = in_target;
          state_d  = EVAL;
        end
      end
      EVAL: begin
        if (counted && resolved_cnt_q != CNT_MAX) resolved_cnt_d = resolved_cnt_q + CNT_W'(1);
        if (taken && taken_cnt_q != CNT_MAX)      taken_cnt_d    = taken_cnt_q + CNT_W'(1);
        state_d = taken ? REDIRECT : IDLE;
      end
      REDIRECT: begin
        if (redirect_ready) begin
          fcnt_d  = FLUSH_LOAD;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Counter reads 0 in the last flush cycle, so width is FLUSH_LOAD+1.
        if (fcnt_q == '0) state_d = IDLE;
        else              fcnt_d  = fcnt_q - FLUSH_CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      branch_q       <= 1'b0;
      jump_q         <= 1'b0;
      funct3_q       <= 3'b000;
      flags_q        <= '0;
      target_q       <= '0;
      fcnt_q         <= '0;
      taken_cnt_q    <= '0;
      resolved_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      branch_q       <= branch_d;
      jump_q         <= jump_d;
      funct3_q       <= funct3_d;
      flags_q        <= flags_d;
      target_q       <= target_d;
      fcnt_q         <= fcnt_d;
      taken_cnt_q    <= taken_cnt_d;
      resolved_cnt_q <= resolved_cnt_d;
    end
  end

  // Outputs come only from state and captured registers.
  assign in_ready       = (state_q == IDLE);
  assign redirect_valid = (state_q == REDIRECT);
  assign flush          = (state_q == FLUSH);
  assign redirect_pc    = target_q;
  assign illegal        = (state_q == EVAL) & branch_q & ~jump_q & ~legal;
  assign taken_cnt      = taken_cnt_q;
  assign resolved_cnt   = resolved_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench: three parameterisations share stimulus buses, each with its own
// in_valid; table vectors, randomized model-checked traffic, saturation and reset sequences.
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_v [NDUT];
  logic        in_branch, in_jump;
  logic [2:0]  in_funct3;
  logic        in_zero, in_lt, in_ltu;
  logic [31:0] in_target;
  logic        redirect_ready;

  logic        in_ready_v [NDUT];
  logic        rv_v       [NDUT];
  logic        fl_v       [NDUT];
  logic        il_v       [NDUT];
  logic [31:0] pc_v       [NDUT];
  logic [15:0] tc_v       [NDUT];
  logic [15:0] rc_v       [NDUT];
  logic [3:0]  tc_b, rc_b, tc_c, rc_c;

  int n_vec  = 0;
  int n_fail = 0;
  int exp_tc [NDUT];
  int exp_rc [NDUT];

  typedef struct {
    logic        br;
    logic        jp;
    logic [2:0]  f3;
    logic        z;
    logic        lt;
    logic        ltu;
    logic [31:0] tgt;
    int          hold;
    logic        tk;
    logic        il;
  } vec_t;

  vec_t tbl [12];

  always #5 clk = ~clk;

  branch_resolve u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_branch(in_branch), .in_jump(in_jump), .in_funct3(in_funct3),
    .in_zero(in_zero), .in_lt(in_lt), .in_ltu(in_ltu), .in_target(in_target),
    .redirect_valid(rv_v[0]), .redirect_ready(redirect_ready), .redirect_pc(pc_v[0]),
    .flush(fl_v[0]), .illegal(il_v[0]), .taken_cnt(tc_v[0]), .resolved_cnt(rc_v[0])
  );

  branch_resolve #(.FLUSH_CYCLES(1), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_branch(in_branch), .in_jump(in_jump), .in_funct3(in_funct3),
    .in_zero(in_zero), .in_lt(in_lt), .in_ltu(in_ltu), .in_target(in_target),
    .redirect_valid(rv_v[1]), .redirect_ready(redirect_ready), .redirect_pc(pc_v[1]),
    .flush(fl_v[1]), .illegal(il_v[1]), .taken_cnt(tc_b), .resolved_cnt(rc_b)
  );

  branch_resolve #(.FLUSH_CYCLES(15), .CNT_W(4)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_branch(in_branch), .in_jump(in_jump), .in_funct3(in_funct3),
    .in_zero(in_zero), .in_lt(in_lt), .in_ltu(in_ltu), .in_target(in_target),
    .redirect_valid(rv_v[2]), .redirect_ready(redirect_ready), .redirect_pc(pc_v[2]),
    .flush(fl_v[2]), .illegal(il_v[2]), .taken_cnt(tc_c), .resolved_cnt(rc_c)
  );

  assign tc_v[1] = {12'd0, tc_b};
  assign rc_v[1] = {12'd0, rc_b};
  assign tc_v[2] = {12'd0, tc_c};
  assign rc_v[2] = {12'd0, rc_c};

  function automatic int flush_of(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  function automatic int cmax_of(input int d);
    return (d == 0) ? 65535 : 15;
  endfunction

  // Reference behaviour from RISC-V branch semantics.
  function automatic logic model_taken(input logic br, jp, input logic [2:0] f3,
                                       input logic z, lt, ltu);
    if (jp) return 1'b1;
    if (!br) return 1'b0;
    case (f3)
      BEQ:     return z;
      BNE:     return !z;
      BLT:     return lt;
      BGE:     return !lt;
      BLTU:    return ltu;
      BGEU:    return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic model_illegal(input logic br, jp, input logic [2:0] f3);
    return br && !jp && (f3 == 3'b010 || f3 == 3'b011);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    for (int d = 0; d < NDUT; d++) begin
      exp_tc[d] = 0;
      exp_rc[d] = 0;
    end
  endtask

  task automatic run_txn(input int d, input logic br, jp, input logic [2:0] f3,
                         input logic z, lt, ltu, input logic [31:0] tgt, input int hold,
                         input logic tk, il);
    int n;
    n = 0;
    while (!in_ready_v[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(in_ready_v[d]), 32'd1);
    in_valid_v[d]  = 1'b1;
    in_branch      = br;
    in_jump        = jp;
    in_funct3      = f3;
    in_zero        = z;
    in_lt          = lt;
    in_ltu         = ltu;
    in_target      = tgt;
    redirect_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    in_valid_v[d] = 1'b0;
    in_target     = $urandom;
    {in_zero, in_lt, in_ltu} = 3'($urandom);
    check("eval_in_ready", 32'(in_ready_v[d]), 32'd0);
    check("eval_illegal", 32'(il_v[d]), 32'(il));
    check("eval_no_redirect", 32'(rv_v[d]), 32'd0);
    @(negedge clk);
    if ((br || jp) && exp_rc[d] < cmax_of(d)) exp_rc[d]++;
    if (tk && exp_tc[d] < cmax_of(d)) exp_tc[d]++;
    check("taken_cnt", 32'(tc_v[d]), 32'(exp_tc[d]));
    check("resolved_cnt", 32'(rc_v[d]), 32'(exp_rc[d]));
    check("illegal_pulse_end", 32'(il_v[d]), 32'd0);
    redirect_ready = 1'b0;
    if (!tk) begin
      check("nt_idle", 32'(in_ready_v[d]), 32'd1);
      check("nt_no_redirect", 32'(rv_v[d]), 32'd0);
    end else begin
      for (int i = 0; i < hold; i++) begin
        check("rv_hold", 32'(rv_v[d]), 32'd1);
        check("pc_hold", pc_v[d], tgt);
        in_target = $urandom;
        @(negedge clk);
      end
      check("redirect_valid", 32'(rv_v[d]), 32'd1);
      check("redirect_pc", pc_v[d], tgt);
      check("no_flush_in_redirect", 32'(fl_v[d]), 32'd0);
      redirect_ready = 1'b1;
      @(negedge clk);
      redirect_ready = 1'b0;
      n = 0;
      while (fl_v[d] && n < 40) begin
        n++;
        @(negedge clk);
      end
      check("flush_width", 32'(n), 32'(flush_of(d)));
      check("post_flush_ready", 32'(in_ready_v[d]), 32'd1);
      check("post_flush_rv", 32'(rv_v[d]), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            br    jp    f3      z     lt    ltu   tgt            hold tk    il
    tbl[0]  = '{1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 3'b101, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 3'b110, 1'b0, 1'b0, 1'b1, 32'h0000_2000, 5, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 32'h0000_3000, 0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 1'b1, 32'h0000_4000, 0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 32'h0000_5000, 0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 3'b001, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEE0, 1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 3'b100, 1'b1, 1'b0, 1'b1, 32'h0000_7000, 0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 3'b111, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 2, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0000_9000, 0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 3'b011, 1'b1, 1'b1, 1'b1, 32'h0000_A000, 0, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 0, 1'b1, 1'b0};

    rst_n          = 1'b0;
    in_branch      = 1'b0;
    in_jump        = 1'b0;
    in_funct3      = 3'b000;
    in_zero        = 1'b0;
    in_lt          = 1'b0;
    in_ltu         = 1'b0;
    in_target      = '0;
    redirect_ready = 1'b0;
    for (int d = 0; d < NDUT; d++) in_valid_v[d] = 1'b0;
    reset_model();
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check("rst_in_ready", 32'(in_ready_v[d]), 32'd1);
      check("rst_rv", 32'(rv_v[d]), 32'd0);
      check("rst_pc", pc_v[d], 32'd0);
      check("rst_flush", 32'(fl_v[d]), 32'd0);
      check("rst_illegal", 32'(il_v[d]), 32'd0);
      check("rst_taken_cnt", 32'(tc_v[d]), 32'd0);
      check("rst_resolved_cnt", 32'(rc_v[d]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_txn(0, tbl[i].br, tbl[i].jp, tbl[i].f3, tbl[i].z, tbl[i].lt, tbl[i].ltu,
              tbl[i].tgt, tbl[i].hold, tbl[i].tk, tbl[i].il);

    for (int i = 0; i < 40; i++) begin
      logic br, jp, z, lt, ltu;
      logic [2:0] f3;
      br  = ($urandom_range(0, 3) != 0);
      jp  = ($urandom_range(0, 4) == 0);
      f3  = 3'($urandom);
      z   = 1'($urandom);
      lt  = 1'($urandom);
      ltu = 1'($urandom);
      run_txn(0, br, jp, f3, z, lt, ltu, $urandom, int'($urandom_range(0, 3)),
              model_taken(br, jp, f3, z, lt, ltu), model_illegal(br, jp, f3));
    end

    for (int i = 0; i < 20; i++)
      run_txn(1, 1'b1, 1'b0, BEQ, 1'b1, 1'b0, 1'b0, $urandom, 0, 1'b1, 1'b0);
    check("sat_taken_cnt", 32'(tc_v[1]), 32'd15);
    check("sat_resolved_cnt", 32'(rc_v[1]), 32'd15);
    run_txn(1, 1'b1, 1'b0, BNE, 1'b1, 1'b0, 1'b0, $urandom, 0, 1'b0, 1'b0);
    check("sat_resolved_hold", 32'(rc_v[1]), 32'd15);

    run_txn(2, 1'b0, 1'b1, BEQ, 1'b0, 1'b0, 1'b0, 32'h0000_C000, 0, 1'b1, 1'b0);
    run_txn(2, 1'b1, 1'b0, BGEU, 1'b0, 1'b0, 1'b0, 32'h0000_C100, 3, 1'b1, 1'b0);

    // Asynchronous reset while a redirect is pending.
    in_valid_v[0] = 1'b1;
    in_branch     = 1'b1;
    in_jump       = 1'b0;
    in_funct3     = BEQ;
    in_zero       = 1'b1;
    in_target     = 32'h0000_0ABC;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    @(negedge clk);
    check("rst_pre_rv", 32'(rv_v[0]), 32'd1);
    redirect_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rv", 32'(rv_v[0]), 32'd0);
    check("async_rst_flush", 32'(fl_v[0]), 32'd0);
    check("async_rst_in_ready", 32'(in_ready_v[0]), 32'd1);
    check("async_rst_pc", pc_v[0], 32'd0);
    check("async_rst_taken_cnt", 32'(tc_v[0]), 32'd0);
    reset_model();
    @(negedge clk);
    redirect_ready = 1'b0;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_no_flush", 32'(fl_v[0]), 32'd0);
      check("post_rst_in_ready", 32'(in_ready_v[0]), 32'd1);
    end
    run_txn(0, 1'b1, 1'b0, BLT, 1'b0, 1'b1, 1'b0, 32'h0000_0444, 0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Branch/jump resolution stage for the RISC-V datapath, placed directly downstream of the ALU comparator flags and upstream of fetch. It latches one control-transfer instruction, selects the relevant comparison flag with a `bitmux` instance (N=3), applies the funct3 polarity bit, and issues a PC redirect to fetch over a valid/ready handshake. After the redirect it asserts a multi-cycle flush and keeps saturating taken/resolved statistics counters.

## Interface
Parameters:
- `XLEN`, 32: PC/target width.
- `FLUSH_CYCLES`, 2: cycles `flush` stays high after a redirect handshake; legal range 1..15.
- `CNT_W`, 16: statistics counter width.

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream offers an instruction.
- `in_ready`  out  1  stage can accept.
- `in_branch`  in  1  conditional branch.
- `in_jump`  in  1  unconditional jump (JAL/JALR). Takes priority over `in_branch`.
- `in_funct3`  in  3  branch funct3.
- `in_zero`, `in_lt`, `in_ltu`  in  1 each  comparator flags: a==b, signed a<b, unsigned a<b.
- `in_target`  in  XLEN  resolved target address.
- `redirect_valid`  out  1  redirect request to fetch.
- `redirect_ready`  in  1  fetch accepts redirect.
- `redirect_pc`  out  XLEN  redirect address.
- `flush`  out  1  squash younger instructions.
- `illegal`  out  1  one-cycle pulse: branch with funct3[2:1]=01.
- `taken_cnt`, `resolved_cnt`  out  CNT_W  saturating statistics.

## Operation
- FSM states: IDLE, EVAL, REDIRECT, FLUSH. Reset -> IDLE.
- IDLE: `in_ready`=1. On `in_valid`: capture all `in_*` fields and go to EVAL. If neither branch nor jump is set, capture is still taken (treated as not-taken, not counted).
- EVAL: the flag vector is {ltu, lt, zero} (bit0 = zero). The bitmux sel is derived from funct3[2:1]: 00->0, 10->1, 11->2. For 01, sel is don't-care, not-taken is forced, and `illegal` pulses. taken = jump | (branch & legal & (flag ^ funct3[0])). When branch|jump, `resolved_cnt`+=1. When taken, `taken_cnt`+=1. Both saturate at all-ones. Next state is REDIRECT if taken, otherwise IDLE.
- REDIRECT: `redirect_valid`=1, `redirect_pc`=captured target, held stable until `redirect_ready`. The handshake completes in the cycle both are high; the next state is FLUSH, with the counter loaded to FLUSH_CYCLES-1.
- FLUSH: `flush`=1. Decrement each cycle and go to IDLE in the cycle after the counter reads 0. Exactly FLUSH_CYCLES cycles of `flush`.
- `in_ready`=0 in EVAL, REDIRECT, FLUSH. Upstream holds its data.

## Timing
- Reset values: `in_ready`=1 (IDLE), `redirect_valid`=0, `redirect_pc`=0, `flush`=0, `illegal`=0, both counters 0.
- Latency: accept at edge T. EVAL occupies cycle T+1. `redirect_valid` is first high in cycle T+2.
- Not-taken throughput: one instruction per 2 cycles.
- Redirect-to-IDLE: with `redirect_ready` already high, 1 + FLUSH_CYCLES cycles.
- `redirect_ready` high outside REDIRECT is ignored.
- Counter saturation: at max, an increment holds the value. Both counters are updated in the same edge.
- Reset asserted mid-operation (any state) returns to IDLE immediately (asynchronous). Outputs return to reset values. Any pending redirect is dropped with no flush.
- All outputs are registered or decoded from state only; there is no combinational path from `in_*` or `redirect_ready` to outputs.

## Structure
- Shared package: state encoding (2-bit IDLE=0, EVAL=1, REDIRECT=2, FLUSH=3), the funct3 field constants BEQ/BNE/BLT/BGE/BLTU/BGEU, and the flag-index constants FLAG_ZERO=0, FLAG_LT=1, FLAG_LTU=2.
- One sub-module: the existing `bitmux` with N=3 performs flag selection. The FSM, counters and capture registers live in `branch_resolve`.

## Test plan
- BEQ (funct3=000), zero=1, target=0x100, ready held high -> redirect_valid in cycle T+2 with pc=0x100, then flush high for exactly 2 cycles, taken_cnt=1, resolved_cnt=1.
- BGE (101), lt=1 -> not taken: no redirect, back in IDLE at T+2. BLTU (110), ltu=1, redirect_ready low for 5 cycles -> redirect_valid and pc stable for 5 cycles, then FLUSH.
- Jump with branch=1, funct3=011 -> taken to target, no illegal pulse. Branch with funct3=010 -> illegal pulses for one cycle, not taken, resolved_cnt increments.
- CNT_W=4, 20 taken branches -> taken_cnt saturates at 15. resolved_cnt also at 15.
- Assert rst_n during REDIRECT -> redirect_valid drops asynchronously, no flush, in_ready=1 after release.
- FLUSH_CYCLES=1 and 15 -> flush width is 1 and 15 cycles respectively.
